// File: rtl/ctr_4bit_pkg.sv
// rtl/ctr_4bit_pkg.sv - shared constants and state encoding for the 4-bit counter interface
package ctr_4bit_pkg;

    localparam int   CTR_W     = 4;
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

endpackage

// File: rtl/ctr_4bit_step.sv
// rtl/ctr_4bit_step.sv - combinational up/down step with 4-bit wrap, shared by counter and monitor
module ctr_4bit_step
    import ctr_4bit_pkg::*;
(
    input  logic [CTR_W-1:0] v,
    input  logic             m,
    output logic [CTR_W-1:0] y
);

    assign y = (m == MODE_DOWN) ? v - CTR_W'(1) : v + CTR_W'(1);

endmodule

// File: rtl/ctr_4bit_monitor.sv
// rtl/ctr_4bit_monitor.sv - passive up/down counter sequence checker; CTR_4BIT_MONITOR_STICKY_EN enables FAULT hold
module ctr_4bit_monitor
    import ctr_4bit_pkg::*;
#(
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [CTR_W-1:0] r,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CTR_W-1:0] expect_val
);

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [CTR_W-1:0] prev_q;
    logic             prev_mode_q;
    logic [CTR_W-1:0] step_y;
    logic             match;
    logic             err_d;
    logic             count_err;
    logic [ERR_W-1:0] err_cnt_base;
    logic [ERR_W-1:0] err_cnt_d;

    ctr_4bit_step u_step (
        .v (prev_q),
        .m (prev_mode_q),
        .y (step_y)
    );

    // Nothing has been sampled yet in IDLE, so the prediction reads as zero there.
    assign expect_val = (state_q == ST_IDLE) ? '0 : step_y;
    assign match      = (r == step_y);

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        err_d     = 1'b0;
        count_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_SYNC;
                run_d   = '0;
            end
            ST_SYNC: begin
                if (match) begin
                    run_d = run_q + 4'd1;
                    if (run_q + 4'd1 == LOCK_C) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    run_d = '0;
                end
            end
            ST_LOCKED: begin
                if (!match) begin
                    err_d     = 1'b1;
                    count_err = 1'b1;
                    run_d     = '0;
`ifdef CTR_4BIT_MONITOR_STICKY_EN
                    state_d   = ST_FAULT;
`else
                    state_d   = ST_SYNC;
`endif
                end
            end
            ST_FAULT: begin
`ifdef CTR_4BIT_MONITOR_STICKY_EN
                if (clr) begin
                    state_d = ST_SYNC;
                    run_d   = '0;
                end else begin
                    err_d   = 1'b1;
                end
`else
                state_d = ST_SYNC;
                run_d   = '0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        endcase
    end

    // Clear is applied first so a simultaneous error still leaves a count of one.
    always_comb begin
        err_cnt_base = clr ? '0 : err_cnt;
        err_cnt_d    = err_cnt_base;
        if (count_err && (err_cnt_base != '1)) begin
            err_cnt_d = err_cnt_base + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            run_q       <= '0;
            prev_q      <= '0;
            prev_mode_q <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            prev_q      <= r;
            prev_mode_q <= mode;
            locked      <= (state_d == ST_LOCKED);
            err         <= err_d;
            err_cnt     <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_ctr_4bit_monitor.sv
// tb/tb_ctr_4bit_monitor.sv - directed and random checks of ctr_4bit_monitor against a sequence model
module tb_ctr_4bit_monitor;

    localparam int LOCK_CNT = 2;
    localparam int ERR_W    = 2;
    localparam int CNT_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mode = 1'b0;
    logic [3:0]       r = 4'd0;
    logic             clr = 1'b0;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       expect_val;

    int checks   = 0;
    int failures = 0;

    bit m_started, m_locked, m_err, m_fault;
    int m_streak, m_cnt, m_pr, m_pm;
    int last_r, last_m;

    ctr_4bit_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .r          (r),
        .clr        (clr),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt),
        .expect_val (expect_val)
    );

    always #5 clk = ~clk;

    function automatic int nxt(input int v, input int m);
        return (m != 0) ? (v + 15) % 16 : (v + 1) % 16;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_locked = 0; m_err = 0; m_fault = 0;
        m_streak = 0; m_cnt = 0; m_pr = 0; m_pm = 0;
    endtask

    task automatic model_edge(input int rv, input int mv, input int cv);
        bit counted;
        counted = 0;
        if (!m_started) begin
            m_started = 1; m_streak = 0; m_locked = 0; m_err = 0;
        end else if (m_fault) begin
            if (cv != 0) begin
                m_fault = 0; m_err = 0; m_streak = 0;
            end else begin
                m_err = 1;
            end
        end else if (m_locked) begin
            if (rv == nxt(m_pr, m_pm)) begin
                m_err = 0;
            end else begin
                m_err = 1; counted = 1; m_locked = 0; m_streak = 0;
`ifdef CTR_4BIT_MONITOR_STICKY_EN
                m_fault = 1;
`endif
            end
        end else begin
            m_err = 0;
            if (rv == nxt(m_pr, m_pm)) begin
                m_streak++;
                if (m_streak == LOCK_CNT) m_locked = 1;
            end else begin
                m_streak = 0;
            end
        end
        if (cv != 0) m_cnt = 0;
        if (counted && m_cnt < CNT_MAX) m_cnt++;
        m_pr = rv;
        m_pm = mv;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".locked"}, int'(locked), int'(m_locked));
        check({tag, ".err"}, int'(err), int'(m_err));
        check({tag, ".err_cnt"}, int'(err_cnt), m_cnt);
        check({tag, ".expect"}, int'(expect_val), m_started ? nxt(m_pr, m_pm) : 0);
    endtask

    task automatic drive(input string tag, input int rv, input int mv, input int cv);
        r    = 4'(rv);
        mode = (mv != 0);
        clr  = (cv != 0);
        @(posedge clk);
        model_edge(rv, mv, cv);
        #1;
        check_outputs(tag);
        last_r = rv;
        last_m = mv;
        @(negedge clk);
    endtask

    task automatic good(input string tag, input int n, input int mv);
        for (int i = 0; i < n; i++) drive(tag, nxt(last_r, last_m), mv, 0);
    endtask

    task automatic bad(input string tag, input int cv);
        drive(tag, (nxt(last_r, last_m) + 5) % 16, 0, cv);
    endtask

    initial begin
        model_reset();
        last_r = 0;
        last_m = 0;
        #1 rst = 1'b0;
        #2;
        check("rst.locked", int'(locked), 0);
        check("rst.err", int'(err), 0);
        check("rst.err_cnt", int'(err_cnt), 0);
        check("rst.expect", int'(expect_val), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 3; v <= 6; v++) drive("lock", v, 0, 0);
        check("lock.exp7", int'(expect_val), 7);
        check("lock.hold", int'(locked), 1);

        for (int v = 14; v <= 16; v++) drive("wrap_up", v % 16, 0, 0);
        drive("wrap_dn", 1, 1, 0);
        drive("wrap_dn", 0, 1, 0);
        drive("wrap_dn", 15, 1, 0);
        drive("wrap_dn", 14, 1, 0);

        drive("relock", 5, 0, 0);
        drive("relock", 6, 0, 0);
        drive("relock", 9, 0, 0);
        drive("relock", 10, 0, 0);
        drive("relock", 11, 0, 0);

        good("dir", 3, 0);
        drive("dir", 5, 0, 0);
        drive("dir", 6, 0, 0);
        drive("dir", 7, 1, 0);
        drive("dir", 6, 1, 0);
        drive("dir", 5, 1, 0);

        drive("sat_clr0", 6, 0, 1);
        for (int k = 0; k < 5; k++) begin
            good("sat", 3, 0);
            bad("sat", 0);
        end
`ifndef CTR_4BIT_MONITOR_STICKY_EN
        check("sat.cnt3", int'(err_cnt), CNT_MAX);
`endif
        good("clr", 1, 0);
        drive("clr_only", nxt(last_r, last_m), 0, 1);
        check("clr.cnt0", int'(err_cnt), 0);
        good("clr_err", 3, 0);
        bad("clr_err", 1);
`ifndef CTR_4BIT_MONITOR_STICKY_EN
        check("clr_err.cnt1", int'(err_cnt), 1);
`endif

        good("hold", 4, 0);
        bad("hold", 0);
        good("hold", 10, 0);
        drive("hold_clr", nxt(last_r, last_m), 0, 1);
        good("hold", 4, 0);

        good("arst", 4, 0);
        #2 rst = 1'b0;
        #1;
        check("arst.locked", int'(locked), 0);
        check("arst.err", int'(err), 0);
        check("arst.err_cnt", int'(err_cnt), 0);
        check("arst.expect", int'(expect_val), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive("arst_idle", int'($urandom_range(0, 15)), 0, 0);
        good("arst", 4, 0);

        for (int i = 0; i < 3000; i++) begin
            int rv, mv, cv;
            rv = nxt(last_r, last_m);
            if ($urandom_range(0, 7) == 0) rv = int'($urandom_range(0, 15));
            mv = last_m;
            if ($urandom_range(0, 7) == 0) mv = 1 - last_m;
            cv = ($urandom_range(0, 15) == 0) ? 1 : 0;
            drive("rand", rv, mv, cv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctr_4bit_monitor.md
Name: ctr_4bit_monitor

Overview:
Passive checker at the consuming end of the 4-bit up/down counter interface (mode, r).
- Samples the counter's r and mode every clock.
- Locks onto the count sequence and flags any step that breaks the up/down rule.
- Keeps a saturating error count.
- Used in lab test harnesses and as a self-check on counter outputs.

Parameters:
LOCK_CNT, 2, consecutive correct steps required to enter LOCKED (1..15)
ERR_W, 8, width of error counter err_cnt

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
mode  input  1  counter direction observed: 0 = up (+1), 1 = down (-1)
r  input  4  observed counter value
clr  input  1  synchronous clear of err_cnt (and FAULT, if feature enabled)
locked  output  1  high while state = LOCKED
err  output  1  one-cycle pulse on detected mismatch while LOCKED
err_cnt  output  ERR_W  saturating count of detected mismatches
expect  output  4  value r must take at the next edge

Behaviour:
- Single clock. Reset is asynchronous and active-low on rst: rst low forces state=IDLE, prev=0, prev_mode=0, run=0, locked=0, err=0, err_cnt=0, expect=0, immediately and independent of clk.
- Step function: step(v, m) = v+1 mod 16 if m=0, else v-1 mod 16. Arithmetic is 4-bit wrap, so 15→0 (up) and 0→15 (down) are legal.
- Sampling rule: r and mode sampled at edge t give expect = step(r_t, mode_t). At edge t+1 the sample r_{t+1} "matches" iff r_{t+1} == expect.
- Every edge: prev<=r, prev_mode<=mode, expect<=step(r, mode), in all states.
- Direction changes are legal at any edge; mode takes effect at the edge it is sampled.
- State machine:
  - IDLE: capture only; no comparison; go to SYNC with run=0. This is the first edge after reset.
  - SYNC: on match, run<=run+1, and if run+1==LOCK_CNT go to LOCKED. On mismatch, run<=0 and stay in SYNC. err is never asserted in SYNC.
  - LOCKED: on match, stay. On mismatch: err=1 for exactly one cycle, err_cnt increments, run<=0, go to SYNC.
- locked is a registered output, high in the cycle after the edge that enters LOCKED.
- err_cnt saturates at 2^ERR_W-1; once there, further errors still pulse err.
- clr: err_cnt<=0. If clr and a counted error occur on the same edge, err_cnt<=1 (clear applies, then the error is counted).
- clr does not affect state or lock.
- Latency: mismatch at edge t produces err high in cycle t→t+1.

Optional Feature:
CTR_4BIT_MONITOR_STICKY_EN
- Defined: a mismatch in LOCKED goes to state FAULT instead of SYNC.
  - In FAULT, err is held high, locked=0, and no comparison is made; expect/prev still track r.
  - clr in FAULT returns to SYNC with run=0 and err_cnt=0.
  - err_cnt counts at most one per FAULT entry.
- Undefined: FAULT does not exist; err is a one-cycle pulse as above.

Decomposition:
- Package ctr_4bit_pkg:
  - CTR_W=4
  - MODE_UP=0, MODE_DOWN=1
  - state encoding: IDLE=2'd0, SYNC=2'd1, LOCKED=2'd2, FAULT=2'd3
- Sub-module ctr_4bit_step: combinational step(v, m). Shared with the counter so both ends use identical wrap rules.
- ctr_4bit_monitor holds the FSM, run counter, expect register and err_cnt.

Test Plan:
- Lock and hold (LOCK_CNT=2): release rst, drive mode=0 with r=3,4,5,6 on successive edges → locked=0 after edges 1–2, locked=1 after edge 3; err=0 throughout; expect=7 after edge 4.
- Wrap-around: mode=0, r=14,15,0,1 → locked after third edge, no err. Then mode=1, r=1,0,15,14 → still locked, no err.
- Mismatch and relock: locked, up-counting r=5,6,9 → err=1 for one cycle after the edge sampling 9, err_cnt=1, locked=0. Then r=10,11 → locked=1 again after the edge sampling 11.
- Direction change: r=5,6 with mode=0, then r=7 sampled with mode=1, then r=6,5 → no err; locked stays 1.
- Saturation and clr (ERR_W=2): force 5 locked mismatches → err_cnt=3, five err pulses. Assert clr alone → 0. Assert clr on an error edge → 1.
- Async reset mid-LOCKED: drop rst between edges → locked, err, err_cnt=0 before the next edge. After release, first edge is IDLE capture with no err even if r is arbitrary.
- With STICKY_EN, mismatch in LOCKED → err stays 1 for 10 cycles and err_cnt=1. clr → err=0 and state SYNC.
